polaris_fetch: RTL
==================

Name: polaris_fetch

Overview:
Parametrised instruction-fetch/prefetch unit for the next Polaris core generation. Owns the fetch PC, drives the I-master bus and buffers up to DEPTH fetched 32-bit words, each tagged with its PC, in a FIFO. The core consumes entries over a valid/ready interface and redirects fetch on jumps, branches and traps. Adds prefetch, redirect/flush and a misalignment jam that the single-word, sequencer-driven fetch path never had.

Parameters:
AW, 64, address width of fetch PC and iadr_o (32 or 64).
DEPTH, 4, FIFO entries; power of two, 2..16.
RESET_VECTOR, {AW{1'b1}} with low 8 bits 0 (0x...FF00), PC loaded at reset.

Ports:
clk_i  in  1  clock; all state updates on its rising edge.
reset_i  in  1  asynchronous, active-low reset.
icyc_o  out  1  bus cycle in progress.
istb_o  out  1  request strobe; iadr_o/isiz_o valid while high.
iadr_o  out  AW  fetch address; 0 when istb_o low.
isiz_o  out  2  2'b10 (32-bit) while istb_o high, else 2'b00.
iack_i  in  1  bus acknowledge; idat_i valid in the same cycle.
idat_i  in  32  fetched instruction word.
ivalid_o  out  1  FIFO head valid.
iready_i  in  1  core accepts head; pop when ivalid_o & iready_i.
ir_o  out  32  head instruction.
ipc_o  out  AW  head PC.
redir_i  in  1  redirect/flush strobe, one cycle.
redir_pc_i  in  AW  new fetch PC.
jammed_o  out  1  fetch halted on misaligned PC.
perf_fetch_o  out  32  fetched-word counter (see Optional Feature).

Behaviour:
- Reset (reset_i low, asynchronous): fpc=RESET_VECTOR, FIFO empty, state IDLE; icyc_o=istb_o=ivalid_o=jammed_o=0, iadr_o=0, isiz_o=0, ir_o=0, ipc_o=0, perf_fetch_o=0. Release is synchronous to clk_i; first istb_o rises on the first edge after release.
- States: IDLE, REQ, JAM.
- IDLE -> REQ when count < DEPTH and no redirect this cycle.
- REQ: icyc_o=istb_o=1, iadr_o=fpc. Address and strobe are stable until iack_i.
- REQ on iack_i: push {idat_i, fpc} and set fpc=fpc+4 (wraps modulo 2^AW). If count after the push is < DEPTH, stay in REQ; the next address is issued the following cycle. Otherwise go to IDLE. One bus request is outstanding at most.
- Push and pop in the same cycle: count is unchanged. A pop on a full FIFO in the same cycle as iack_i is legal.
- ivalid_o=(count!=0). ir_o/ipc_o are driven from the head register; no bypass, so a word acked in cycle N is visible at N+1.
- redir_i (any state): FIFO flushed (count=0, ivalid_o=0 next cycle) and any iack_i in the same cycle is discarded. The bus cycle is abandoned: istb_o and icyc_o are low for exactly one cycle. If redir_pc_i[1:0]==0: fpc=redir_pc_i, go to IDLE. Otherwise: fpc=redir_pc_i, go to JAM.
- redir_i has priority over push, pop and jam.
- JAM: jammed_o=1, no bus activity, FIFO empty. Leave only by a redir_i with an aligned PC.
- A pop while ivalid_o=0 is ignored.

Optional Feature:
Macro POLARIS_FETCH_PERF_EN.
- Defined: perf_fetch_o counts accepted iack_i pushes, including those later flushed but excluding those discarded in a redirect cycle. It is 32-bit and wraps to 0. It resets only on reset_i.
- Undefined: perf_fetch_o is constant 0 and the counter logic is not built.

Test Plan:
1. Reset release, iack_i=1 every cycle, iready_i=0 -> iadr_o sequence FF00, FF04, FF08, FF0C (upper bits all ones); after 4 acks istb_o=0 and ivalid_o=1. ir_o shows the first word, ipc_o=...FF00.
2. Full FIFO, then iready_i=1 for one cycle -> one pop. Next cycle istb_o=1 with iadr_o=...FF10. ipc_o advances to ...FF04.
3. iack_i delayed 3 cycles -> iadr_o and istb_o stay stable for all 4 cycles; exactly one push.
4. redir_i=1, redir_pc_i=0x1000, with iack_i=1 in the same cycle -> data discarded, ivalid_o=0 next cycle, one idle bus cycle, then iadr_o=0x1000. First popped ipc_o=0x1000.
5. redir_pc_i=0x1002 -> jammed_o=1, no istb_o for 10 cycles. Then redir_pc_i=0x2000 -> jammed_o=0 and fetch resumes at 0x2000.
6. reset_i asserted mid-REQ, asynchronously between edges -> all outputs go to 0 immediately, without waiting for an edge. With POLARIS_FETCH_PERF_EN defined, after 5 accepted acks perf_fetch_o=5.

Source files
------------

// File: rtl/polaris_fetch_if.sv
// polaris_fetch_if: bundles the I-master bus and the core-side fetch
// interface of polaris_fetch.
//   master modport (fetch unit):
//     bus  : icyc_o, istb_o, iadr_o[AW], isiz_o[2] out; iack_i, idat_i[32] in
//     core : ivalid_o, ir_o[32], ipc_o[AW], jammed_o, perf_fetch_o[32] out;
//            iready_i, redir_i, redir_pc_i[AW] in
//   slave modport: the same signals seen from the bus/core side.
interface polaris_fetch_if #(
  parameter int unsigned AW = 64
);
  logic          icyc_o;
  logic          istb_o;
  logic [AW-1:0] iadr_o;
  logic [1:0]    isiz_o;
  logic          iack_i;
  logic [31:0]   idat_i;
  logic          ivalid_o;
  logic          iready_i;
  logic [31:0]   ir_o;
  logic [AW-1:0] ipc_o;
  logic          redir_i;
  logic [AW-1:0] redir_pc_i;
  logic          jammed_o;
  logic [31:0]   perf_fetch_o;

  modport master (
    output icyc_o, istb_o, iadr_o, isiz_o,
    input  iack_i, idat_i,
    output ivalid_o, ir_o, ipc_o, jammed_o, perf_fetch_o,
    input  iready_i, redir_i, redir_pc_i
  );

  modport slave (
    input  icyc_o, istb_o, iadr_o, isiz_o,
    output iack_i, idat_i,
    input  ivalid_o, ir_o, ipc_o, jammed_o, perf_fetch_o,
    output iready_i, redir_i, redir_pc_i
  );
endinterface

// File: rtl/polaris_fetch.sv
// polaris_fetch: instruction fetch / prefetch unit.
// Owns the fetch PC, issues single-word reads on the I-master bus and
// buffers up to DEPTH {instruction, PC} pairs in a FIFO for the core.
// A redirect flushes the FIFO, abandons the bus cycle and reloads the PC;
// a misaligned redirect target halts fetch (JAM) until an aligned redirect.
// Ports:
//   clk_i    : clock, rising edge
//   reset_i  : asynchronous active-low reset
//   fetch    : polaris_fetch_if.master (bus + core signals)
// Optional: define POLARIS_FETCH_PERF_EN to build the 32-bit fetched-word
// counter on perf_fetch_o; otherwise perf_fetch_o is tied to 0.
module polaris_fetch #(
  parameter int unsigned   AW           = 64,
  parameter int unsigned   DEPTH        = 4,
  parameter logic [AW-1:0] RESET_VECTOR = {{(AW-8){1'b1}}, 8'h00}
) (
  input  logic            clk_i,
  input  logic            reset_i,
  polaris_fetch_if.master fetch
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_JAM
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fpc_q, fpc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [31:0]   ir_mem_q [DEPTH];
  logic [31:0]   ir_mem_d [DEPTH];
  logic [AW-1:0] pc_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_d [DEPTH];

  logic push;
  logic pop;
  logic valid;

  assign valid = (cnt_q != '0);
  // A redirect discards both the acked word and any pop in its cycle.
  assign push  = (state_q == ST_REQ) && fetch.iack_i && !fetch.redir_i;
  assign pop   = valid && fetch.iready_i && !fetch.redir_i;

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    ir_mem_d = ir_mem_q;
    pc_mem_d = pc_mem_q;

    if (fetch.redir_i) begin
      cnt_d = '0;
      wr_d  = '0;
      rd_d  = '0;
      fpc_d = fetch.redir_pc_i;
      // Landing in IDLE (not REQ) gives the one dead bus cycle after a flush.
      state_d = (fetch.redir_pc_i[1:0] == 2'b00) ? ST_IDLE : ST_JAM;
    end else begin
      if (push) begin
        ir_mem_d[wr_q] = fetch.idat_i;
        pc_mem_d[wr_q] = fpc_q;
        wr_d           = wr_q + PW'(1);
        fpc_d          = fpc_q + AW'(4);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);

      // Occupancy is judged after this cycle's push/pop, so a pop from a
      // full FIFO restarts fetch on the very next cycle.
      unique case (state_q)
        ST_IDLE: if (cnt_d < CW'(DEPTH)) state_d = ST_REQ;
        ST_REQ:  if (push && (cnt_d >= CW'(DEPTH))) state_d = ST_IDLE;
        ST_JAM:  state_d = ST_JAM;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= ST_IDLE;
      fpc_q    <= RESET_VECTOR;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      ir_mem_q <= '{default: '0};
      pc_mem_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ir_mem_q <= ir_mem_d;
      pc_mem_q <= pc_mem_d;
    end
  end

  always_comb begin
    fetch.icyc_o   = 1'b0;
    fetch.istb_o   = 1'b0;
    fetch.iadr_o   = '0;
    fetch.isiz_o   = 2'b00;
    fetch.jammed_o = (state_q == ST_JAM);
    fetch.ivalid_o = valid;
    fetch.ir_o     = '0;
    fetch.ipc_o    = '0;
    if (state_q == ST_REQ) begin
      fetch.icyc_o = 1'b1;
      fetch.istb_o = 1'b1;
      fetch.iadr_o = fpc_q;
      fetch.isiz_o = 2'b10;
    end
    // Head is gated so stale entries never show after a flush or drain.
    if (valid) begin
      fetch.ir_o  = ir_mem_q[rd_q];
      fetch.ipc_o = pc_mem_q[rd_q];
    end
  end

`ifdef POLARIS_FETCH_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (push) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) perf_q <= '0;
    else          perf_q <= perf_d;
  end

  assign fetch.perf_fetch_o = perf_q;
`else
  assign fetch.perf_fetch_o = '0;
`endif

endmodule
